// File: rtl/dbus_arbiter.sv
// dbus_arbiter: registered one-outstanding-transaction arbiter merging N request channels onto dbus
module dbus_arbiter #(
  parameter int N = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MODE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           in_valid,
  input  logic [N*ADDR_W-1:0]    in_addr,
  input  logic [N*3-1:0]         in_size,
  input  logic [N*DATA_W/8-1:0]  in_strobe,
  input  logic [N*DATA_W-1:0]    in_data,
  output logic [N-1:0]           in_ok,
  output logic [DATA_W-1:0]      out_rdata,
  output logic                   dreq_valid,
  output logic [ADDR_W-1:0]      dreq_addr,
  output logic [2:0]             dreq_size,
  output logic [DATA_W/8-1:0]    dreq_strobe,
  output logic [DATA_W-1:0]      dreq_data,
  input  logic                   dresp_data_ok,
  input  logic [DATA_W-1:0]      dresp_data,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   busy
);
  localparam int PW = $clog2(N);
  localparam int SW = DATA_W / 8;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [PW-1:0] rr_ptr, win, nxt;
  logic [N-1:0] rot, tmp;
  logic [PW:0] sum;
  logic found;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0] sel_size;
  logic [SW-1:0] sel_strobe;
  logic [DATA_W-1:0] sel_data;
  // rotate so the search always starts at bit 0, then map the offset back to a channel index
  always_comb begin
    rot = MODE != 0 ? N'({in_valid, in_valid} >> rr_ptr) : in_valid;
    tmp = rot;
    found = 1'b0;
    sum = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && tmp[0]) begin
        found = 1'b1;
        sum = (PW+1)'(k);
      end
      tmp = tmp >> 1;
    end
    sum = sum + (MODE != 0 ? {1'b0, rr_ptr} : '0);
    win = sum >= (PW+1)'(N) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
    nxt = win == PW'(N-1) ? '0 : win + 1'b1;
    sel_addr = '0;
    sel_size = '0;
    sel_strobe = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win == PW'(i)) begin
        sel_addr = in_addr[i*ADDR_W +: ADDR_W];
        sel_size = in_size[i*3 +: 3];
        sel_strobe = in_strobe[i*SW +: SW];
        sel_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      dreq_addr <= '0;
      dreq_size <= '0;
      dreq_strobe <= '0;
      dreq_data <= '0;
    end else if (state == IDLE) begin
      if (|in_valid) begin
        state <= BUSY;
        grant_id <= win;
        dreq_addr <= sel_addr;
        dreq_size <= sel_size;
        dreq_strobe <= sel_strobe;
        dreq_data <= sel_data;
        if (MODE != 0) rr_ptr <= nxt;
      end
    end else if (dresp_data_ok) begin
      state <= IDLE;
    end
  end
  assign busy = state == BUSY;
  assign dreq_valid = busy;
  assign in_ok = (busy && dresp_data_ok && !reset) ? N'(1) << grant_id : '0;
  assign out_rdata = |in_ok ? dresp_data : '0;
endmodule

// File: doc/dbus_arbiter.md
# dbus_arbiter

Parametrised data-bus arbiter that merges N load/store request channels from the execute/commit side onto the single `dbus` request/response pair leaving `core`. It replaces the combinational write-over-read mux with a registered, one-outstanding-transaction arbiter. The arbiter selects fixed-priority or round-robin per build, holds the bus stable until `data_ok`, and routes the completion back to the winning channel.

## Interface
- `N`, 2: number of request channels (2..8).
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: data width; strobe width is `DATA_W/8`.
- `MODE`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  N  per-channel request valid; held with payload until that channel's `in_ok`.
- `in_addr`  in  N*ADDR_W  per-channel address, channel i at `[i*ADDR_W +: ADDR_W]`.
- `in_size`  in  N*3  per-channel access size (msize encoding).
- `in_strobe`  in  N*DATA_W/8  per-channel byte strobe; all-zero marks a read.
- `in_data`  in  N*DATA_W  per-channel write data.
- `in_ok`  out  N  one-hot completion pulse to the granted channel.
- `out_rdata`  out  DATA_W  read data, valid when any `in_ok` bit is 1.
- `dreq_valid`, `dreq_addr`, `dreq_size`, `dreq_strobe`, `dreq_data`  out  1/ADDR_W/3/DATA_W/8/DATA_W  registered bus request.
- `dresp_data_ok`  in  1  bus completion.
- `dresp_data`  in  DATA_W  bus read data.
- `grant_id`  out  $clog2(N)  index of the channel owning the bus; meaningful only while `busy` is 1.
- `busy`  out  1  a transaction is outstanding.

## Operation
- Two states: IDLE, BUSY. At most one outstanding transaction.
- **IDLE**, any `in_valid`:
  - Pick a winner.
  - MODE 0: lowest set index.
  - MODE 1: first set index at or after `rr_ptr`, searching upward and wrapping from N-1 to 0.
  - Latch the winner's addr/size/strobe/data into the `dreq_*` registers.
  - Set `grant_id` to the winner.
  - Go to BUSY.
  - MODE 1: `rr_ptr <= (winner+1) mod N`.
- **IDLE**, no `in_valid`: stay in IDLE; `dreq_valid` = 0.
- **BUSY**:
  - `dreq_*` held constant; `dreq_valid` = 1.
  - No new arbitration.
  - `in_valid` of other channels is ignored.
- **BUSY**, `dresp_data_ok` = 1:
  - Same cycle, combinationally: `in_ok[grant_id]` = 1, `out_rdata` = `dresp_data`.
  - Next cycle: state <= IDLE.
- Granted channel drops `in_valid` mid-transaction: the transaction still completes and `in_ok` still pulses. There is no abort.
- `in_ok` is 0 outside a `data_ok` cycle in BUSY. `out_rdata` is don't-care when `in_ok` = 0. The bench checks it only on `in_ok`.
- `dreq_strobe` passes through unmodified. Read vs write is encoded by strobe alone.
- **Reset**, including mid-BUSY, applied next edge:
  - State IDLE, `rr_ptr` = 0.
  - `dreq_valid` = 0, `busy` = 0, `grant_id` = 0, `dreq_*` payload = 0.
  - A `dresp_data_ok` arriving in a reset cycle is dropped: no `in_ok`.

## Timing
- Reset values: `dreq_valid` 0, `dreq_addr` 0, `dreq_size` 0, `dreq_strobe` 0, `dreq_data` 0, `grant_id` 0, `busy` 0.
- `in_ok` and `out_rdata` are combinational from `dresp_data_ok`/`dresp_data`; they are 0 during reset.
- Request latency: `in_valid` first sampled at edge t; `dreq_valid` = 1 from cycle t+1.
- Completion: `dresp_data_ok` in cycle k gives `in_ok` in cycle k. `dreq_valid` = 0 in cycle k+1, the mandatory IDLE bubble. The next grant is captured at the end of k+1.
- Minimum occupancy: `data_ok` in the first BUSY cycle gives a 2-cycle period per transaction.
- No combinational path from `in_*` to `dreq_*`. The only combinational paths are `dresp_*` → `in_ok`/`out_rdata`.
- `busy` equals `dreq_valid`.

## Test plan
- **Single read, N=2 MODE=0:**
  - Stimulus: ch1 `in_valid` with addr 0x8000_1000, strobe 0; `dresp_data_ok` 3 cycles after `dreq_valid` rises, `dresp_data` 0xDEAD_BEEF.
  - Required: `dreq_valid` rises 1 cycle after `in_valid`; `dreq_addr` = 0x8000_1000; `in_ok` = 2'b10 with `out_rdata` 0xDEAD_BEEF in the `data_ok` cycle; `dreq_valid` = 0 on the next cycle.
- **Simultaneous requests, MODE=0:**
  - Stimulus: ch0 write (strobe 0xFF) and ch1 read asserted together; each drops `in_valid` after its `in_ok`.
  - Required: ch0 granted first (`grant_id` 0); ch1 granted in the cycle after the bubble.
  - Required: ch1 stalled while ch0 is BUSY, with no `dreq_*` change.
- **Round-robin, N=4 MODE=1:**
  - Stimulus: all 4 channels held valid and re-requesting immediately after each `in_ok`.
  - Required: grant order 0,1,2,3,0,1 (wrap); no channel granted twice before every other pending channel is granted.
- **Sparse round-robin, N=4 MODE=1:**
  - Stimulus: only ch0 and ch3 valid, `rr_ptr` = 1.
  - Required: ch3 granted, then ch0.
- **Long stall:**
  - Stimulus: `dresp_data_ok` held low for 20 cycles while ch2 and ch0 toggle `in_valid`.
  - Required: `dreq_*` and `grant_id` constant throughout; `in_ok` all-zero until `data_ok`.
- **Reset mid-BUSY:**
  - Stimulus: `reset` asserted while BUSY with `dresp_data_ok` = 1 in the same cycle.
  - Required: `in_ok` = 0; `dreq_valid` = 0 and `busy` = 0 after the edge; with MODE=1, the next grant starts search from ch0.
